// File: rtl/skinny_pkg.sv
// Shared Skinny-128 datapath constants, FSM encodings and cell/state types.
// The round controller imports the same encodings.
package skinny_pkg;

  localparam int CELL_W    = 8;
  localparam int NUM_CELLS = 16;
  localparam int STATE_W   = 128;
  localparam int CNT_W     = $clog2(NUM_CELLS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_e;

  typedef logic [CELL_W-1:0]  cell_t;
  typedef logic [STATE_W-1:0] state_t;
  typedef logic [CNT_W-1:0]   cnt_t;

endpackage

// File: rtl/skinny_subcells_seq_if.sv
// Upstream/downstream valid-ready bundle of the byte-serial SubCells sequencer.
// The slave side belongs to the sequencer; the master side to whoever drives it.
interface skinny_subcells_seq_if;
  import skinny_pkg::*;

  logic   in_valid;
  logic   in_ready;
  state_t in_state;
  logic   abort;
  logic   out_valid;
  logic   out_ready;
  state_t out_state;
  logic   busy;
  cnt_t   cell_idx;

  modport master (
    output in_valid,
    output in_state,
    output abort,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_state,
    input  busy,
    input  cell_idx
  );

  modport slave (
    input  in_valid,
    input  in_state,
    input  abort,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_state,
    output busy,
    output cell_idx
  );

endinterface

// File: rtl/skinny_subcells_seq_sbox.sv
// Combinational 8-bit Skinny S-box: four NOR/XOR mixing layers joined by a
// fixed bit permutation, with bits 1 and 2 exchanged at the very end.
module skinny_subcells_seq_sbox
  import skinny_pkg::*;
(
  input  cell_t din,
  output cell_t dout
);

  function automatic cell_t sbox_mix(cell_t x);
    cell_t y;
    y    = x;
    y[0] = x[0] ^ ~(x[3] | x[2]);
    y[4] = x[4] ^ ~(x[7] | x[6]);
    return y;
  endfunction

  function automatic cell_t sbox_perm(cell_t x);
    return {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
  endfunction

  cell_t work;

  always_comb begin
    work = din;
    for (int r = 0; r < 4; r++) begin
      work = sbox_mix(work);
      if (r < 3) begin
        work = sbox_perm(work);
      end
    end
    dout = {work[7:3], work[1], work[2], work[0]};
  end

endmodule

// File: rtl/skinny_subcells_seq.sv
// Byte-serial SubCells: rotates the 128-bit state left one cell per cycle,
// feeding the leaving top cell through one shared S-box into the bottom slot.
module skinny_subcells_seq
  import skinny_pkg::*;
#(
  parameter int NUM_CELLS = skinny_pkg::NUM_CELLS,
  parameter int CELL_W    = skinny_pkg::CELL_W
) (
  input  logic                 clk,
  input  logic                 rst,
  skinny_subcells_seq_if.slave bus
);

  localparam int CNT_BITS = $clog2(NUM_CELLS);
  localparam int ST_BITS  = NUM_CELLS * CELL_W;

  fsm_state_e          st_q, st_d;
  logic [ST_BITS-1:0]  state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic [CELL_W-1:0]   sbox_out;

  skinny_subcells_seq_sbox u_sbox (
    .din  (state_q[ST_BITS-1 -: CELL_W]),
    .dout (sbox_out)
  );

  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (st_q)
      ST_IDLE: begin
        if (!bus.abort && bus.in_valid) begin
          st_d    = ST_RUN;
          state_d = bus.in_state;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        // abort freezes the partially substituted state where it is
        if (bus.abort) begin
          st_d  = ST_IDLE;
          cnt_d = '0;
        end else begin
          state_d = {state_q[ST_BITS-CELL_W-1:0], sbox_out};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_BITS'(NUM_CELLS - 1)) begin
            st_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (bus.abort || bus.out_ready) begin
          st_d  = ST_IDLE;
          cnt_d = '0;
        end
      end
      default: begin
        st_d  = ST_IDLE;
        cnt_d = '0;
      end
    endcase

    in_ready_d  = (st_d == ST_IDLE);
    out_valid_d = (st_d == ST_DONE);
    busy_d      = (st_d == ST_RUN) || (st_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= ST_IDLE;
      state_q     <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      st_q        <= st_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.out_state = state_q;
  assign bus.cell_idx  = (st_q == ST_RUN) ? cnt_q : '0;

endmodule
